// File: rtl/load_store_unit.sv
// Load/store unit: word-wide data memory initiator with byte/halfword lanes,
// load sign/zero extension and read-modify-write for sub-word stores.
module load_store_unit #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_wen,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   localparam int unsigned BA_W = ADDR_W + 2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t          state;
   logic [BA_W-1:0] addr_q;
   logic [1:0]      size_q;
   logic            we_q;
   logic            sgn_q;
   logic            err_q;
   logic [31:0]     wdata_q;
   logic [31:0]     old_q;
   logic [31:0]     rdata_q;

   logic            req_err_c;
   logic [31:0]     merge_c;
   logic            unused_addr_c;

   // Upper byte-address bits are dropped so out-of-range addresses wrap.
   assign unused_addr_c = ^req_addr[31:BA_W];

   assign req_err_c = (req_size == SZ_BAD) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

   // Select the addressed lane of a memory word and extend it to 32 bits.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [1:0]  off,
                                           input logic [1:0]  size,
                                           input logic        sgn);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (size)
         SZ_BYTE: extract = {{24{sgn & sh[7]}}, sh[7:0]};
         SZ_HALF: extract = {{16{sgn & sh[15]}}, sh[15:0]};
         default: extract = w;
      endcase
   endfunction

   // Replace the addressed lane of the old word; word stores take wdata as-is.
   always_comb begin
      merge_c = old_q;
      case (size_q)
         SZ_BYTE: merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         SZ_HALF: begin
            if (addr_q[1]) merge_c[31:16] = wdata_q[15:0];
            else           merge_c[15:0]  = wdata_q[15:0];
         end
         default: merge_c = wdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr[BA_W-1:0];
                  size_q  <= req_size;
                  we_q    <= req_we;
                  sgn_q   <= req_signed;
                  wdata_q <= req_wdata;
                  err_q   <= req_err_c;
                  if (req_err_c) begin
                     rdata_q <= '0;
                     state   <= RESP;
                  end else if (req_we && (req_size == SZ_WORD)) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  old_q <= mem_read_data;
                  state <= WR;
               end else begin
                  rdata_q <= extract(mem_read_data, addr_q[1:0], size_q, sgn_q);
                  state   <= RESP;
               end
            end
            WR: begin
               rdata_q <= '0;
               state   <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake and memory strobes decode straight from state so reset drops them at once.
   assign req_ready      = (state == IDLE);
   assign busy           = (state != IDLE);
   assign resp_valid     = (state == RESP);
   assign resp_err       = (state == RESP) && err_q;
   assign resp_rdata     = rdata_q;
   assign mem_address    = (state == IDLE) ? '0 : addr_q[BA_W-1:2];
   assign mem_wen        = (state == WR);
   assign mem_write_data = (state == WR) ? merge_c : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: reference model on request acceptance,
// decoupled monitor on responses and memory writes.
module tb_load_store_unit;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              busy;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wen;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .busy           (busy),
      .mem_address    (mem_address),
      .mem_wen        (mem_wen),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Data memory seen by the DUT, and the model's own copy.
   logic [31:0] env_mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   assign mem_read_data = env_mem[mem_address];
   always @(posedge clk) if (mem_wen) env_mem[mem_address] <= mem_write_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } resp_t;
   typedef struct { int idx; logic [31:0] data; } wr_t;
   resp_t rq[$];
   wr_t   wq[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          skip     = 1'b0;
   int          next_ready = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: whole-request semantics computed at acceptance.
   task automatic accept();
      logic [1:0]  off;
      int          idx;
      logic        err;
      logic [31:0] old, v, mask, nw;
      int          lat;
      off = req_addr[1:0];
      idx = int'(req_addr[ADDR_W+1:2]);
      err = (req_size == 2'd3) || (req_size == 2'd1 && off[0]) || (req_size == 2'd2 && off != 2'd0);
      old = ref_mem[idx];
      v   = '0;
      if (err) begin
         lat = 1;
      end else if (!req_we) begin
         lat = 2;
         v = old >> (8 * off);
         if (req_size == 2'd0) begin
            v = v & 32'hFF;
            if (req_signed && v[7]) v = v | 32'hFFFF_FF00;
         end else if (req_size == 2'd1) begin
            v = v & 32'hFFFF;
            if (req_signed && v[15]) v = v | 32'hFFFF_0000;
         end else begin
            v = old;
         end
      end else begin
         if (req_size == 2'd2) begin
            lat = 2;
            nw  = req_wdata;
         end else begin
            lat  = 3;
            mask = ((req_size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
            nw   = (old & ~mask) | ((req_wdata << (8 * off)) & mask);
         end
         ref_mem[idx] = nw;
         wq.push_back('{idx, nw});
      end
      rq.push_back('{v, err, cyc, lat});
      next_ready = cyc + lat + 1;
   endtask

   // Observer: handshake timing against the model, then capture accepted requests.
   always @(negedge clk) begin
      if (rst || skip) begin
         next_ready = 0;
      end else begin
         check("req_ready", 64'(req_ready), 64'(cyc >= next_ready));
         check("busy", 64'(busy), 64'(cyc < next_ready));
         if (cyc >= next_ready)
            check("idle_bus", {mem_wen, 13'(mem_address), 18'd0, mem_write_data}, 64'd0);
         if (req_valid && req_ready) accept();
      end
   end

   // Monitor: pop expectations whenever the DUT presents a response or a write.
   always @(negedge clk) begin
      if (!rst && !skip) begin
         if (resp_valid) begin
            if (rq.size() == 0) begin
               check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
               resp_t r;
               r = rq.pop_front();
               check("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
               check("resp_err", 64'(resp_err), 64'(r.err));
               check("latency", 64'(cyc - r.acc), 64'(r.lat));
               last_rdata = resp_rdata;
               last_err   = resp_err;
            end
         end else begin
            check("err_without_valid", 64'(resp_err), 64'd0);
         end
         if (mem_wen) begin
            if (wq.size() == 0) begin
               check("unexpected_write", 64'(mem_wen), 64'd0);
            end else begin
               wr_t w;
               w = wq.pop_front();
               check("wr_addr", 64'(mem_address), 64'(w.idx));
               check("wr_data", 64'(mem_write_data), 64'(w.data));
            end
         end
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge clk);
      #1;
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      wait_idle();
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         logic [31:0] r;
         r = $urandom;
         env_mem[i] = r;
         ref_mem[i] = r;
      end
      repeat (3) @(negedge clk);
      check("rst_ready_busy", {62'd0, req_ready, busy}, 64'd2);
      check("rst_resp", {31'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
      check("rst_mem", {mem_wen, 13'(mem_address), 18'd0, mem_write_data}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Word store then load.
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      check("lw_deadbeef", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

      // Byte store read-modify-write.
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
      do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      check("sb_merge", 64'(last_rdata), 64'h0000_0000_11AA_3344);

      // Signed and unsigned sub-word loads.
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80F0_7F01);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      check("lb_13", 64'(last_rdata), 64'h0000_0000_FFFF_FF80);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      check("lbu_13", 64'(last_rdata), 64'h0000_0000_0000_0080);
      do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      check("lh_12", 64'(last_rdata), 64'h0000_0000_FFFF_80F0);
      do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      check("lhu_10", 64'(last_rdata), 64'h0000_0000_0000_7F01);

      // Misaligned and illegal requests.
      do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
      check("lw_12_err", {31'd0, last_err, last_rdata}, 64'h1_0000_0000);
      do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF);
      check("sh_11_err", {31'd0, last_err, last_rdata}, 64'h1_0000_0000);
      do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
      check("size3_err", {31'd0, last_err, last_rdata}, 64'h1_0000_0000);

      // Reset during the write cycle of a byte store.
      skip = 1'b1;
      @(posedge clk);
      #1;
      req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h12; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_wen) begin
               seen = 1'b1;
               break;
            end
         end
         check("rmw_reaches_wr", 64'(seen), 64'd1);
      end
      rst = 1'b1;
      #1;
      check("rst_drops_wen", {62'd0, mem_wen, resp_valid}, 64'd0);
      check("rst_ready", {62'd0, req_ready, busy}, 64'd2);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_resp_after_rst", {62'd0, resp_valid, req_ready}, 64'd1);
      end
      check("rst_word_kept", 64'(env_mem[4]), 64'h0000_0000_80F0_7F01);
      skip = 1'b0;

      // Randomized traffic with req_valid changing every cycle.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] hi;
         logic [1:0]  off;
         logic [1:0]  sz;
         @(posedge clk);
         #1;
         sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         off = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) off = off & 2'b10;
            if (sz == 2'd2) off = 2'b00;
         end
         hi = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_F000) : 32'h0;
         req_valid  = ($urandom_range(0, 4) != 0);
         req_we     = 1'($urandom_range(0, 1));
         req_size   = sz;
         req_signed = 1'($urandom_range(0, 1));
         req_addr   = hi | (32'($urandom_range(0, 15)) << 2) | 32'(off);
         req_wdata  = $urandom;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (8) @(negedge clk);

      check("resp_queue_drained", 64'(rq.size()), 64'd0);
      check("write_queue_drained", 64'(wq.size()), 64'd0);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < int'(DEPTH); i++)
            if (env_mem[i] !== ref_mem[i]) bad++;
         check("memory_image", 64'(bad), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-wide data memory: accepts load/store requests from the MEM stage and drives the memory's word address, write enable and write data.
- The memory reads combinationally and writes on the clock edge.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Sub-word stores use a read-modify-write sequence; the pipeline is stalled while the unit is busy.

Parameters:
- ADDR_W, 10, width of the memory word address; maps to byte-address bits [ADDR_W+1:2].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend the load result (ignored for word and store)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word sizes
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned or illegal-size request; valid with resp_valid
- busy  out  1  stall to the pipeline; equals state != IDLE
- mem_address  out  ADDR_W  word address to the data memory
- mem_wen  out  1  memory write enable
- mem_write_data  out  32  memory write word
- mem_read_data  in  32  combinational memory read word

Behaviour:
- States: IDLE, RD, WR, RESP. Reset enters IDLE.
- Request capture: a request is accepted when req_valid && req_ready. At that edge, addr, size, we, signed and wdata are registered. Inputs are ignored outside IDLE.
- Error check at acceptance:
  - size 11 → error.
  - halfword with addr[0]=1 → error.
  - word with addr[1:0]!=0 → error.
  - Error path: IDLE→RESP with resp_err=1, resp_rdata=0; no memory write.
- Transitions:
  - Load: IDLE→RD→RESP. In RD, mem_read_data is sampled and the lane extracted into the resp_rdata register.
  - Word store: IDLE→WR→RESP.
  - Byte/halfword store: IDLE→RD→WR→RESP. In RD, the old word is latched. In WR, the selected lane is replaced with req_wdata[7:0] or [15:0]; other lanes keep the old value.
  - RESP→IDLE unconditionally.
- Latency (acceptance edge to resp_valid high):
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back: a new request can be accepted no earlier than the cycle after RESP.
- Byte lanes are little-endian:
  - addr[1:0]=0 → bits[7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24].
  - Halfword addr[1]=0 → [15:0], addr[1]=1 → [31:16].
- Load extension: sign-extend from bit 7/15 when req_signed=1, else zero-extend.
- mem_address:
  - equals registered addr[ADDR_W+1:2] in RD, WR and RESP; 0 in IDLE.
  - upper address bits are discarded, so out-of-range addresses wrap.
- mem_wen and mem_write_data:
  - mem_wen is decoded combinationally from state and is high only in WR.
  - mem_write_data is the merged/word data in WR, else 0.
- Outputs:
  - resp_valid and resp_err are high only in RESP.
  - resp_rdata is registered and holds its value until the next load or error completes; stores set it to 0.
- Reset:
  - Resets to IDLE; req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_address=0, mem_write_data=0.
  - Reset asserted mid-operation (including during WR) forces IDLE immediately and drops mem_wen before the next edge, so no write occurs. An in-flight request is dropped with no response.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF → mem_wen for 1 cycle at word 4, resp_valid 2 cycles after acceptance. Load from 0x10 → resp_rdata=0xDEADBEEF after 2 cycles.
- Byte store RMW: word 4 = 0x11223344; sb addr 0x12, data 0xAA → word becomes 0x11AA3344, resp_valid 3 cycles after acceptance, exactly one mem_wen pulse.
- Signed/unsigned loads: word 4 = 0x80F07F01.
  - lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080.
  - lh 0x12 → 0xFFFF80F0; lhu 0x10 → 0x00007F01.
- Misaligned and illegal: lw 0x12, sh 0x11 and size 11 → resp_err=1 one cycle after acceptance, resp_rdata=0, no mem_wen.
- Handshake: hold req_valid high continuously with requests changing each cycle → req_ready low in RD/WR/RESP, only IDLE-cycle requests accepted, busy matches state.
- Reset mid-RMW: assert rst during WR of an sb → mem_wen drops before the edge, memory word unchanged, no resp_valid, req_ready=1 after reset releases.
